// File: rtl/counter_x_pkg.sv
// counter_x_pkg: shared constants for the three-channel down-counter peripheral
package counter_x_pkg;
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_SQUARE   = 2'b10;
    localparam logic [1:0] CH0     = 2'd0;
    localparam logic [1:0] CH1     = 2'd1;
    localparam logic [1:0] CH2     = 2'd2;
    localparam logic [1:0] CH_CTRL = 2'd3;
    localparam int CTRL_W = 12;
endpackage

// File: rtl/counter_chan.sv
// counter_chan: one 32-bit down-counter channel with one-shot, periodic and square modes
module counter_chan
    import counter_x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        load_we,
    input  logic [31:0] load_val,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic        mode_chg,
    output logic [31:0] count,
    output logic        out
);
    logic [31:0] load;
    logic act, last, reload;
    assign act    = tick && en && load != 32'd0;
    assign last   = count <= 32'd1;
    assign reload = mode == MODE_PERIODIC || mode == MODE_SQUARE;
    // mode 2'b11 falls through to one-shot behaviour
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load  <= '0;
            count <= '0;
            out   <= 1'b0;
        end else if (load_we) begin
            load  <= load_val;
            count <= load_val;
            if (mode != MODE_SQUARE) out <= 1'b0;
        end else begin
            if (act) count <= !last ? count - 32'd1 : reload ? load : 32'd0;
            if (mode_chg) out <= 1'b0;
            else if (mode == MODE_PERIODIC) out <= act && last;
            else if (mode == MODE_SQUARE) out <= out ^ (act && last);
            else if (act && last) out <= 1'b1;
        end
    end
endmodule

// File: rtl/counter_x.sv
// counter_x: three-channel programmable down-counter with shared prescaler,
// control register, write demux and combinational read mux
module counter_x
    import counter_x_pkg::*;
#(
    parameter int PRESC_DIV = 1,
    parameter int PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        counter_we,
    input  logic [1:0]  counter_ch,
    input  logic [31:0] counter_val,
    output logic [31:0] counter_out,
    output logic        counter0_out,
    output logic        counter1_out,
    output logic        counter2_out
);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
    logic [PRESC_W-1:0] presc;
    logic [CTRL_W-1:0]  ctrl;
    logic [31:0]        count [3];
    logic [2:0]         done;
    logic               tick, ctrl_we;
    assign tick    = presc == PRESC_LAST;
    assign ctrl_we = counter_we && counter_ch == CH_CTRL;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            ctrl  <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (ctrl_we) ctrl <= counter_val[CTRL_W-1:0];
        end
    end
    for (genvar i = 0; i < 3; i++) begin : g_chan
        counter_chan u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .load_we (counter_we && counter_ch == 2'(i)),
            .load_val(counter_val),
            .en      (ctrl[4*i]),
            .mode    (ctrl[4*i+2:4*i+1]),
            .mode_chg(ctrl_we && counter_val[4*i+2:4*i+1] != ctrl[4*i+2:4*i+1]),
            .count   (count[i]),
            .out     (done[i])
        );
    end
    assign counter_out = counter_ch == CH0 ? count[0] :
                         counter_ch == CH1 ? count[1] :
                         counter_ch == CH2 ? count[2] : {{(32-CTRL_W){1'b0}}, ctrl};
    assign {counter2_out, counter1_out, counter0_out} = done;
endmodule

// File: tb/tb_counter_x.sv
// tb_counter_x: directed self-checking bench for counter_x (PRESC_DIV=1 and PRESC_DIV=4 instances)
module tb_counter_x;
    logic        clk = 1'b0, rst = 1'b0, we = 1'b0;
    logic [1:0]  ch = 2'd0;
    logic [31:0] val = '0;
    logic [31:0] a_out, b_out;
    logic        a0, a1, a2, b0, b1, b2;
    int total = 0, bad = 0;

    counter_x dut_a (
        .clk(clk), .rst(rst), .counter_we(we), .counter_ch(ch), .counter_val(val),
        .counter_out(a_out), .counter0_out(a0), .counter1_out(a1), .counter2_out(a2)
    );
    counter_x #(.PRESC_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .counter_we(we), .counter_ch(ch), .counter_val(val),
        .counter_out(b_out), .counter0_out(b0), .counter1_out(b1), .counter2_out(b2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] c, input logic [31:0] exp);
        ch = c;
        #1;
        check(tag, a_out, exp);
    endtask

    // called at a negedge; the write is sampled at the next posedge, returns at the following negedge
    task automatic wr(input logic [1:0] c, input logic [31:0] v);
        ch = c;
        val = v;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        int n;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 4; c++) rd("rst_read", 2'(c), 32'd0);
        check("rst_outs", {29'd0, a2, a1, a0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd("ctrl_after_rst", 2'd3, 32'd0);
        @(negedge clk);

        wr(2'd3, 32'h001);
        wr(2'd0, 32'd5);
        rd("os_load", 2'd0, 32'd5);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            rd("os_count", 2'd0, 32'(5 - j));
            check("os_out", {31'd0, a0}, {31'd0, j == 5});
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("os_hold_out", {31'd0, a0}, 32'd1);
            rd("os_hold_cnt", 2'd0, 32'd0);
        end

        wr(2'd3, 32'h030);
        rd("ctrl_read", 2'd3, 32'h030);
        wr(2'd1, 32'd3);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            rd("per_count", 2'd1, j % 3 == 0 ? 32'd3 : 32'(3 - j % 3));
            check("per_out", {31'd0, a1}, {31'd0, j % 3 == 0});
        end

        wr(2'd3, 32'h500);
        check("modechg_clr", {31'd0, a1}, 32'd0);
        wr(2'd2, 32'd4);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            rd("sq_count", 2'd2, j % 4 == 0 ? 32'd4 : 32'(4 - j % 4));
            check("sq_out", {31'd0, a2}, 32'((j / 4) % 2));
        end

        wr(2'd3, 32'h001);
        check("sq_modechg_clr", {31'd0, a2}, 32'd0);
        wr(2'd0, 32'd10);
        rd("frz_load", 2'd0, 32'd10);
        @(negedge clk);
        @(negedge clk);
        wr(2'd3, 32'h000);
        rd("frz_last_tick", 2'd0, 32'd7);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            rd("frz_hold", 2'd0, 32'd7);
        end
        wr(2'd3, 32'h001);
        rd("frz_reen", 2'd0, 32'd7);
        @(negedge clk);
        rd("frz_resume", 2'd0, 32'd6);

        wr(2'd0, 32'd100);
        rd("collide", 2'd0, 32'd100);

        wr(2'd0, 32'd0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            rd("idle_cnt", 2'd0, 32'd0);
            check("idle_out", {31'd0, a0}, 32'd0);
        end

        wr(2'd0, 32'd2);
        check("presc_cleared", {31'd0, b0}, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b0 && n < 12);
        check("presc_rise", {31'd0, b0}, 32'd1);
        check("presc_lat", {31'd0, n >= 5 && n <= 8}, 32'd1);

        wr(2'd3, 32'h011);
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd50);
        @(negedge clk);
        check("pre_rst_out0", {31'd0, a0}, 32'd1);
        rd("pre_rst_cnt1", 2'd1, 32'd49);
        #2 rst = 1'b0;
        #1;
        check("async_rst_outs", {29'd0, a2, a1, a0}, 32'd0);
        for (int c = 0; c < 4; c++) rd("async_rst_read", 2'(c), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_x.md
# counter_x

Three-channel 32-bit programmable down-counter peripheral on the MIO bus at the `f0000004` counter slot. It takes the write strobe and data that the bus decoder routes to the counter slot. It returns a selected count value on `counter_out` and three per-channel done flags on `counter0_out`..`counter2_out`. It is a single-clock block, and all counting is timed by an internal shared prescaler.

## Interface
- `PRESC_DIV`, default 1: clock cycles per count tick. Must be ≥1. A value of 1 means one tick every cycle.
- `PRESC_W`, default 16: prescaler counter width. Requires PRESC_DIV ≤ 2^PRESC_W.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `counter_we`  in  1  write strobe from the bus decoder, one cycle per write.
- `counter_ch`  in  2  register select: 0 = ch0 load, 1 = ch1 load, 2 = ch2 load, 3 = control.
- `counter_val`  in  32  write data, taken from the bus `Peripheral_in`.
- `counter_out`  out  32  read data. For ch 0–2 it is that channel's current count. For ch 3 it is {20'b0, ctrl[11:0]}.
- `counter0_out`, `counter1_out`, `counter2_out`  out  1 each  per-channel done/wave output.

## Operation
- **Control register, 12 bits.** Each channel n owns ctrl[4n+3:4n].
  - Bit 0 = enable.
  - Bits 2:1 = mode: 00 one-shot, 01 periodic, 10 square, 11 treated as one-shot.
  - Bit 3 is reserved. It is stored and read back but has no effect.
- **Per-channel state:** `load` (32 bits), `count` (32 bits) and `out` (1 bit).
- **Write to a load register (ch n, n = 0–2):**
  - `load` and `count` take `counter_val`.
  - `out` is cleared, except in square mode, where `out` is held.
- **Write to control (ch 3):**
  - ctrl takes `counter_val[11:0]`; counts are untouched.
  - Any channel whose mode field changes has its `out` cleared.
- **Tick:** the prescaler counts 0..PRESC_DIV-1 freely and asserts `tick` when it wraps to 0. A channel acts on a tick only if it is enabled and `load` ≠ 0.
- **One-shot mode:**
  - On a tick with `count` > 1: decrement.
  - On a tick with `count` = 1: `count` goes to 0 and `out` goes to 1.
  - At `count` = 0 the channel holds, with `out` = 1, until the next load write.
- **Periodic mode:**
  - On a tick with `count` > 1: decrement.
  - On a tick with `count` = 1: `count` reloads from `load` and `out` pulses high for exactly one clock cycle.
- **Square mode:** same reload rule as periodic, but `out` toggles at each reload instead of pulsing. The output period is 2·load ticks.
- **Disabled channel:** `count` and `out` freeze. Re-enabling resumes from the frozen count.
- **`load` = 0 (channel idle):** `count` stays 0, `out` stays 0, and no underflow ever occurs.
- **Precedence:** a load write to a channel in the same cycle as its tick takes the write; that tick is lost. A control write in the same cycle as a tick applies the new enables and modes starting from the next tick; the current tick uses the old ctrl.
- **Arithmetic:** unsigned 32-bit. No count wraps below 0.

## Timing
- **Reset (`rst` low):** immediately and asynchronously sets the following, all of which hold while `rst` is low:
  - `count` = 0, `load` = 0, ctrl = 0, prescaler = 0;
  - `counter0_out`..`counter2_out` = 0;
  - `counter_out` = 0.
- **Read:** `counter_out` is a combinational mux of registered state on `counter_ch`. It has zero cycles of latency, matching the bus's combinational read path.
- **Write latency:** a write sampled at rising edge k is visible on `counter_out` after edge k.
- **Countdown latency, with PRESC_DIV = 1 and the channel enabled:**
  - A load of V at edge k gives `count` = V−j after edge k+j.
  - One-shot: `out` rises after edge k+V.
  - Periodic: the first pulse follows edge k+V, repeating every V cycles.
- **Prescaler phase:** with PRESC_DIV > 1 the prescaler is never realigned by writes. The first tick therefore lands 1..PRESC_DIV cycles after the write.
- **Control bits:** a control write at edge k takes effect on ticks from edge k+1 onward.
- **Output timing:** outputs are registered and change only on clock edges, apart from reset.

## Structure
- **Package `counter_x_pkg`:**
  - mode constants: MODE_ONESHOT = 2'b00, MODE_PERIODIC = 2'b01, MODE_SQUARE = 2'b10;
  - select codes: CH0 = 0, CH1 = 1, CH2 = 2, CH_CTRL = 3;
  - CTRL_W = 12.
- **Sub-module `counter_chan`, instantiated three times.** Inputs: `clk`, `rst`, `tick`, `load_we`, `load_val`, `en`, `mode`, `mode_chg`. Outputs: `count`, `out`.
- **Top level:** prescaler, ctrl register, write demux and read mux.

## Test plan
- **Reset:** pulse `rst` low mid-countdown → all outputs 0 immediately; `counter_out` reads 0 on every select.
- **One-shot, PRESC_DIV = 1:** ctrl = 0x001, then load ch0 = 5 → `count` reads 4, 3, 2, 1, 0 on consecutive cycles; `counter0_out` rises with `count` = 0 and stays 1 for 20 further cycles.
- **Periodic:** ctrl = 0x030 (ch1 enabled, periodic), load ch1 = 3 → `counter1_out` one-cycle pulses at cycles 3, 6, 9 after the write; `count` sequence 2, 1, 3, 2, 1, 3.
- **Square:** ctrl = 0x500 (ch2 enabled, square), load ch2 = 4 → `counter2_out` toggles every 4 cycles, giving a period of 8.
- **Freeze and collisions:**
  - Disable ch0 at `count` = 7 → `count` holds 7 for 10 cycles, then resumes at 6 one cycle after re-enable.
  - Load write coinciding with a tick → `count` equals the written value.
- **Idle and prescaler:** load ch0 = 0 with the channel enabled → `count` stays 0 and `counter0_out` stays 0. With PRESC_DIV = 4, load 2 → `out` rises between 5 and 8 cycles after the write.
